multi_trace_buffer: RTL and testbench
=====================================

# multi_trace_buffer

Instruction trace capture buffer sitting directly downstream of the multicycle RISC-V core. It consumes the core's `PC`, `Instr` and `Estado` outputs. Each time the control FSM enters the decode state, it records one `{PC, Instr}` entry, tagged with a sequence number, into a small register FIFO. A valid/ready read port drains the entries to a debug host or display driver. The FIFO supports stop-when-full and ring (overwrite-oldest) modes, with overflow accounting.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; power of two, at least 2.
- `CAPTURE_STATE`, 4'd1: `Estado` value in which `Instr` holds the fetched instruction (decode state).
- `WRAP`, 0: 0 = drop new entries when full; 1 = overwrite the oldest entry when full.

Ports:
- `CLOCK`  in  1  sole clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Estado`  in  4  core FSM state.
- `PC`  in  32  core program counter.
- `Instr`  in  32  core instruction register.
- `arm`  in  1  level; capture events are recognised only while high.
- `clear`  in  1  synchronous flush, one-cycle pulse.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_valid`  out  1  head entry available.
- `rd_pc`  out  32  head entry PC.
- `rd_instr`  out  32  head entry instruction.
- `rd_seq`  out  16  head entry sequence number.
- `count`  out  $clog2(DEPTH)+1  number of stored entries.
- `overflow`  out  1  sticky; set when an event is dropped or an entry is overwritten.
- `drop_cnt`  out  16  number of lost entries; saturates at 16'hFFFF.

## Operation
- **Edge detector:**
  - `prev_estado` register samples `Estado` on every clock edge.
  - Its reset value is `~CAPTURE_STATE`.
- **Capture event (cap):** `arm & (Estado == CAPTURE_STATE) & (prev_estado != CAPTURE_STATE)`.
  - Exactly one event per decode visit, however many cycles the core stays in that state.
- **Sequence counter:**
  - `seq` is 16 bits.
  - On every cap, the current `seq` is attached to the event and `seq` then increments, wrapping at 16'hFFFF to 0.
  - Dropped events still consume a number, so gaps in `rd_seq` expose losses.
- **Storage and pointers:**
  - Registers `DEPTH` x 80 bits, holding `{PC, Instr, seq}`.
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo `DEPTH`.
- **Pop:** `rd_valid & rd_ready`. Advances `rd_ptr` and decrements `count`.
- **Push when not full (count < DEPTH):** write at `wr_ptr`, advance `wr_ptr`, increment `count`.
- **Push when full, WRAP=0, no simultaneous pop:**
  - Entry discarded.
  - `overflow` <= 1; `drop_cnt` increments (saturating).
- **Push when full, WRAP=1, no simultaneous pop:**
  - Write at `wr_ptr` and advance both `wr_ptr` and `rd_ptr`; `count` stays at `DEPTH`.
  - `overflow` <= 1; `drop_cnt` increments.
- **Push and pop in the same cycle:**
  - Always accepted in both modes; `count` unchanged.
  - No overflow, even when full.
- **Clear:**
  - Zeroes `count`, both pointers, `seq`, `overflow` and `drop_cnt`.
  - Has priority over a simultaneous push or pop; that event is ignored.
  - `prev_estado` still samples `Estado` normally.
- **Read port:**
  - First-word fall-through: `rd_pc`, `rd_instr`, `rd_seq` come combinationally from the entry at `rd_ptr`.
  - `rd_valid = (count != 0)`.
  - When empty, `rd_pc`, `rd_instr` and `rd_seq` are driven to 0.
- **Arithmetic:** all counters are unsigned; `drop_cnt` never wraps.

## Timing
- **Reset (`Reset`=0, asynchronous):**
  - `rd_valid`=0, `rd_pc`=0, `rd_instr`=0, `rd_seq`=0, `count`=0, `overflow`=0, `drop_cnt`=0.
  - Internal state: `seq`=0, pointers=0, `prev_estado`=`~CAPTURE_STATE`.
  - Storage contents need not be reset.
- **Reset release:**
  - Takes effect at the next rising edge.
  - If `Estado==CAPTURE_STATE` and `arm`=1 on the first edge, that edge is a capture.
- **Capture latency:** `Estado`, `PC` and `Instr` are sampled at edge k. The entry appears on the read port (if it is the head) and in `count` immediately after edge k.
- **Pop:** takes effect at the edge where `rd_valid & rd_ready`=1. The next entry is presented after that edge, allowing one pop per cycle.
- **Reset mid-operation:** all entries are lost and outputs return to their reset values asynchronously.

## Test plan
- **Basic capture:** after reset, `arm`=1; drive `Estado` sequence 0,1,1,2,0,1 with PC=0x00400000, then 0x00400004 -> two entries, `rd_seq` 0 and 1, `rd_pc` 0x00400000 then 0x00400004, `count`=2.
- **Arm gating:** with `arm`=0 through one decode visit, then `arm`=1 for the next -> exactly one entry, `rd_seq`=0.
- **WRAP=0 fill:**
  - DEPTH=4; 6 captures, no reads -> `count`=4, `overflow`=1, `drop_cnt`=2.
  - Drain -> `rd_seq` 0,1,2,3.
- **WRAP=1 fill:** DEPTH=4; 6 captures -> `count`=4, `drop_cnt`=2, drain yields `rd_seq` 2,3,4,5.
- **Full with simultaneous push and pop:** DEPTH=4, full, `rd_ready`=1 on the capture edge -> `count` stays 4, `overflow` stays 0, head advances by one.
- **Clear and async reset:**
  - `clear` on the same edge as a capture -> `count`=0, `seq`=0, next capture has `rd_seq`=0.
  - `Reset` low mid-drain -> `rd_valid`=0 immediately.

Source files
------------

// File: rtl/multi_trace_buffer.sv
// Purpose: captures one {PC, Instr, seq} trace entry per decode-state visit of the core into a register FIFO.
// Latency: an entry sampled at edge k is visible on the read port and in count right after edge k.
// Backpressure: the read port is valid/ready; when full, new events are dropped (WRAP=0) or overwrite the oldest (WRAP=1).
//
// Ports:
//   CLOCK, Reset             clock and asynchronous active-low reset
//   Estado, PC, Instr        core FSM state, program counter and instruction register
//   arm                      capture enable (level)
//   clear                    synchronous flush of contents, counters and sticky status
//   rd_valid/rd_ready        head-entry handshake; rd_pc/rd_instr/rd_seq carry the head entry (0 when empty)
//   count                    number of stored entries
//   overflow, drop_cnt       sticky loss flag and saturating count of lost entries
module multi_trace_buffer #(
  parameter int          DEPTH         = 16,
  parameter logic [3:0]  CAPTURE_STATE = 4'd1,
  parameter int          WRAP          = 0
) (
  input  logic                    CLOCK,
  input  logic                    Reset,
  input  logic [3:0]              Estado,
  input  logic [31:0]             PC,
  input  logic [31:0]             Instr,
  input  logic                    arm,
  input  logic                    clear,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [31:0]             rd_pc,
  output logic [31:0]             rd_instr,
  output logic [15:0]             rd_seq,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [15:0]             drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam bit            RING     = (WRAP != 0);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] seq;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [3:0]      r_prev_estado;
  logic [15:0]     r_seq;
  logic [15:0]     r_drop_cnt;
  logic            r_overflow;

  logic            w_valid;
  logic            w_full;
  logic            w_cap;
  logic            w_pop;
  logic            w_wr;
  logic            w_lost;
  logic            w_ovw;
  entry_t          w_head;

  // Rising edge into the capture state gives exactly one event per decode visit.
  // clear masks both the event and any pop on the same edge.
  always_comb begin
    w_valid = (r_count != '0);
    w_full  = (r_count == FULL_CNT);
    w_cap   = arm && (Estado == CAPTURE_STATE) && (r_prev_estado != CAPTURE_STATE) && !clear;
    w_pop   = w_valid && rd_ready && !clear;
    // A simultaneous pop frees the slot, so a full buffer still accepts the entry.
    w_wr    = w_cap && (!w_full || w_pop || RING);
    w_lost  = w_cap && w_full && !w_pop;
    // Ring mode: overwriting the oldest entry drags the read pointer along.
    w_ovw   = w_lost && RING;
  end

  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      r_prev_estado <= ~CAPTURE_STATE;
    end else begin
      r_prev_estado <= Estado;
    end
  end

  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Lost events still consume a sequence number so gaps reveal them downstream.
      if (w_cap) begin
        r_seq <= r_seq + 16'd1;
      end
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop || w_ovw) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_wr && !w_pop && !w_full) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_wr) begin
        r_count <= r_count - CNT_ONE;
      end
      if (w_lost) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

  // Storage is deliberately left without reset; count gates visibility.
  always_ff @(posedge CLOCK) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= '{pc: PC, instr: Instr, seq: r_seq};
    end
  end

  // First-word fall-through read port, zeroed while empty.
  always_comb begin
    w_head   = r_mem[r_rd_ptr];
    rd_valid = w_valid;
    rd_pc    = w_valid ? w_head.pc    : 32'd0;
    rd_instr = w_valid ? w_head.instr : 32'd0;
    rd_seq   = w_valid ? w_head.seq   : 16'd0;
    count    = r_count;
    overflow = r_overflow;
    drop_cnt = r_drop_cnt;
  end

endmodule

// File: tb/tb_multi_trace_buffer.sv
// Bench for multi_trace_buffer: three instances (16-deep drop, 4-deep drop, 4-deep ring) share the core-side stimulus.
// Inputs change 1 time unit after each rising edge; outputs are checked before the next edge.
// Each instance has its own rd_ready so one can be drained while the others hold.
module tb_multi_trace_buffer;

  logic        CLOCK;
  logic        Reset;
  logic [3:0]  Estado;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        arm;
  logic        clear;
  logic        rdy_a, rdy_b, rdy_c;

  logic        a_vld, b_vld, c_vld;
  logic [31:0] a_pc, b_pc, c_pc;
  logic [31:0] a_ins, b_ins, c_ins;
  logic [15:0] a_seq, b_seq, c_seq;
  logic [4:0]  a_cnt;
  logic [2:0]  b_cnt, c_cnt;
  logic        a_ovf, b_ovf, c_ovf;
  logic [15:0] a_drop, b_drop, c_drop;

  int n_checks = 0;
  int n_bad    = 0;

  multi_trace_buffer #(.DEPTH(16), .CAPTURE_STATE(4'd1), .WRAP(0)) u_a (
    .CLOCK(CLOCK), .Reset(Reset), .Estado(Estado), .PC(PC), .Instr(Instr),
    .arm(arm), .clear(clear), .rd_ready(rdy_a), .rd_valid(a_vld), .rd_pc(a_pc),
    .rd_instr(a_ins), .rd_seq(a_seq), .count(a_cnt), .overflow(a_ovf), .drop_cnt(a_drop));

  multi_trace_buffer #(.DEPTH(4), .CAPTURE_STATE(4'd1), .WRAP(0)) u_b (
    .CLOCK(CLOCK), .Reset(Reset), .Estado(Estado), .PC(PC), .Instr(Instr),
    .arm(arm), .clear(clear), .rd_ready(rdy_b), .rd_valid(b_vld), .rd_pc(b_pc),
    .rd_instr(b_ins), .rd_seq(b_seq), .count(b_cnt), .overflow(b_ovf), .drop_cnt(b_drop));

  multi_trace_buffer #(.DEPTH(4), .CAPTURE_STATE(4'd1), .WRAP(1)) u_c (
    .CLOCK(CLOCK), .Reset(Reset), .Estado(Estado), .PC(PC), .Instr(Instr),
    .arm(arm), .clear(clear), .rd_ready(rdy_c), .rd_valid(c_vld), .rd_pc(c_pc),
    .rd_instr(c_ins), .rd_seq(c_seq), .count(c_cnt), .overflow(c_ovf), .drop_cnt(c_drop));

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // One decode visit: one cycle in state 1, then one in state 2.
  task automatic visit(input logic [31:0] pc);
    Estado = 4'd1;
    PC     = pc;
    Instr  = ~pc;
    tick();
    Estado = 4'd2;
    tick();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    Reset = 1'b0;
    #2;
    check("rst_a_vld", a_vld, 0);
    check("rst_b_cnt", b_cnt, 0);
    check("rst_c_drop", c_drop, 0);
    Reset = 1'b1;
    tick();
  endtask

  initial begin
    Reset = 1'b0; Estado = 4'd0; PC = 32'd0; Instr = 32'd0;
    arm = 1'b0; clear = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    #12;
    // Reset state
    check("reset_vld",   a_vld, 0);
    check("reset_pc",    a_pc, 0);
    check("reset_instr", a_ins, 0);
    check("reset_seq",   a_seq, 0);
    check("reset_count", a_cnt, 0);
    check("reset_ovf",   a_ovf, 0);
    check("reset_drop",  a_drop, 0);
    Reset = 1'b1;
    tick();

    // Basic capture: Estado 0,1,1,2,0,1
    arm = 1'b1;
    Estado = 4'd0; tick();
    Estado = 4'd1; PC = 32'h0040_0000; Instr = 32'h0000_0013; tick();
    check("basic_cnt1", a_cnt, 1);
    check("basic_seq0", a_seq, 0);
    check("basic_pc0",  a_pc, 32'h0040_0000);
    Estado = 4'd1; tick();
    check("basic_hold_cnt", a_cnt, 1);
    Estado = 4'd2; tick();
    Estado = 4'd0; tick();
    Estado = 4'd1; PC = 32'h0040_0004; Instr = 32'h00a0_0093; tick();
    check("basic_cnt2", a_cnt, 2);
    check("basic_head_pc", a_pc, 32'h0040_0000);
    check("basic_head_instr", a_ins, 32'h0000_0013);
    Estado = 4'd2; rdy_a = 1'b1; tick();
    rdy_a = 1'b0;
    check("basic_pop_cnt", a_cnt, 1);
    check("basic_pop_pc", a_pc, 32'h0040_0004);
    check("basic_pop_instr", a_ins, 32'h00a0_0093);
    check("basic_pop_seq", a_seq, 1);

    // Arm gating
    pulse_reset();
    arm = 1'b0;
    visit(32'h0000_0100);
    check("gate_cnt0", a_cnt, 0);
    arm = 1'b1;
    visit(32'h0000_0200);
    check("gate_cnt1", a_cnt, 1);
    check("gate_seq", a_seq, 0);
    check("gate_pc", a_pc, 32'h0000_0200);

    // Fill with 6 captures, no reads
    pulse_reset();
    for (int i = 0; i < 6; i++) visit(32'h0000_1000 + 32'(4 * i));
    check("fill_a_cnt",  a_cnt, 6);
    check("fill_a_ovf",  a_ovf, 0);
    check("fill_b_cnt",  b_cnt, 4);
    check("fill_b_ovf",  b_ovf, 1);
    check("fill_b_drop", b_drop, 2);
    check("fill_c_cnt",  c_cnt, 4);
    check("fill_c_ovf",  c_ovf, 1);
    check("fill_c_drop", c_drop, 2);
    rdy_b = 1'b1; rdy_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_b_seq", b_seq, 64'(i));
      check("drain_b_pc",  b_pc, 64'(32'h0000_1000 + 32'(4 * i)));
      check("drain_c_seq", c_seq, 64'(i + 2));
      check("drain_c_pc",  c_pc, 64'(32'h0000_1000 + 32'(4 * (i + 2))));
      tick();
    end
    rdy_b = 1'b0; rdy_c = 1'b0;
    check("drained_b_vld", b_vld, 0);
    check("drained_c_vld", c_vld, 0);
    check("drained_b_seq", b_seq, 0);
    visit(32'h0000_1800);
    check("gap_b_seq", b_seq, 6);
    check("gap_c_seq", c_seq, 6);

    // Full with simultaneous push and pop, then a push while full
    pulse_reset();
    for (int i = 0; i < 4; i++) visit(32'h0000_2000 + 32'(4 * i));
    check("pp_b_full", b_cnt, 4);
    Estado = 4'd1; PC = 32'h0000_2100; Instr = 32'h1111_2222;
    rdy_b = 1'b1; rdy_c = 1'b1;
    tick();
    rdy_b = 1'b0; rdy_c = 1'b0;
    check("pp_b_cnt",  b_cnt, 4);
    check("pp_b_ovf",  b_ovf, 0);
    check("pp_b_seq",  b_seq, 1);
    check("pp_c_cnt",  c_cnt, 4);
    check("pp_c_ovf",  c_ovf, 0);
    check("pp_c_seq",  c_seq, 1);
    Estado = 4'd2; tick();
    visit(32'h0000_2200);
    check("full_b_drop", b_drop, 1);
    check("full_b_seq",  b_seq, 1);
    check("full_c_drop", c_drop, 1);
    check("full_c_seq",  c_seq, 2);
    check("full_c_cnt",  c_cnt, 4);

    // Clear on the same edge as a capture
    Estado = 4'd1; PC = 32'h0000_3000; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_a_cnt", a_cnt, 0);
    check("clr_b_vld", b_vld, 0);
    check("clr_b_ovf", b_ovf, 0);
    check("clr_c_drop", c_drop, 0);
    Estado = 4'd2; tick();
    visit(32'h0000_3004);
    check("clr_next_cnt", b_cnt, 1);
    check("clr_next_seq", b_seq, 0);
    check("clr_next_pc",  b_pc, 32'h0000_3004);

    // Reset mid-drain
    visit(32'h0000_3008);
    visit(32'h0000_300c);
    rdy_a = 1'b1; tick();
    check("mid_a_cnt", a_cnt, 2);
    Reset = 1'b0;
    #1;
    check("mid_rst_vld", a_vld, 0);
    check("mid_rst_cnt", a_cnt, 0);
    check("mid_rst_pc",  a_pc, 0);
    rdy_a = 1'b0;
    // Capture on the first edge after release
    Estado = 4'd1; PC = 32'h0000_5000; arm = 1'b1;
    #2;
    Reset = 1'b1;
    tick();
    check("first_edge_cnt", a_cnt, 1);
    check("first_edge_pc",  a_pc, 32'h0000_5000);
    check("first_edge_seq", a_seq, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
